reg_status_file: RTL and testbench
==================================

Name: reg_status_file

Overview:
- Parametrised, multi-port architectural register file with per-register rename status (pending flag plus producing ROB index).
- Serves READ_PAIRS decoder source-operand pairs per cycle and accepts COMMIT_PORTS in-order commits from the reorder buffer.
- Accepts one pending-mark (rename) per cycle.
- Adds same-cycle commit bypass and a registered busy-register counter.

Parameters:
REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero
REG_ID_W, 5, register index width; must satisfy 2**REG_ID_W >= REG_COUNT
DATA_W, 32, register data width
ROB_W, 4, ROB index width
READ_PAIRS, 1, number of decoder source pairs (j,k) served per cycle
COMMIT_PORTS, 1, commits per cycle; port index order = program order, lowest = oldest

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global ready; state updates only when high
flush  in  1  misprediction flush; effective only when rdy_in high
commit_reg_id  in  COMMIT_PORTS*REG_ID_W  commit destinations; 0 = port idle
commit_data  in  COMMIT_PORTS*DATA_W  commit values
commit_rob_id  in  COMMIT_PORTS*ROB_W  committing ROB indices
rob_query_id  out  2*READ_PAIRS*ROB_W  dependency of each source, sent to ROB
rob_query_ready  in  2*READ_PAIRS  ROB entry already has its result
rob_query_data  in  2*READ_PAIRS*DATA_W  ROB entry value
dec_reg_id  in  2*READ_PAIRS*REG_ID_W  source register ids; slot 2p = j, slot 2p+1 = k
dec_data  out  2*READ_PAIRS*DATA_W  operand value
dec_pending  out  2*READ_PAIRS  operand still unresolved
dec_dependency  out  2*READ_PAIRS*ROB_W  producing ROB index
mark_reg_id  in  REG_ID_W  rename destination; 0 = none
mark_rob_id  in  ROB_W  ROB index of the renamed producer
busy_count  out  REG_ID_W+1  registered number of registers with pending set

Behaviour:
- Reset (async, immediate):
  - all data, pending and dependency cleared.
  - busy_count = 0.
  - All outputs derive from this cleared state, so after reset every dec_data = 0, dec_pending = 0, dec_dependency = 0 and rob_query_id = 0.
- Lookup is combinational per slot, evaluated in this priority order:
  - (a) id 0: data 0, pending 0, dependency 0.
  - (b) pending set and some commit port has the same reg id and commit_rob_id == dependency: data = that commit_data (highest matching port), pending 0.
  - (c) pending set and rob_query_ready: data = rob_query_data, pending 0.
  - (d) pending set otherwise: pending 1.
  - (e) not pending: data = stored data, pending 0.
  - dec_dependency and rob_query_id always equal the stored dependency.
- A mark issued this cycle is invisible to lookups until the next cycle.
- Commit, on each rising edge with rdy_in high:
  - Each active port writes data. Several ports naming the same register: highest index wins.
  - pending is cleared if dependency == commit_rob_id, unless mark_reg_id names the same register this cycle.
- Mark: if mark_reg_id != 0, set pending = 1 and dependency = mark_rob_id. Mark overrides a same-cycle commit clear.
- Flush (rdy_in high):
  - all pending and dependency cleared; the mark is dropped.
  - same-cycle commits still write data.
  - data is otherwise retained.
- rdy_in low: no state change; lookups keep operating combinationally on frozen state.
- busy_count: equals the population count of the pending vector after each edge, 0 after flush. It is never negative and never exceeds REG_COUNT-1.
- Writes to register 0 are ignored on both the commit and mark paths.

Optional Feature:
- Macro: REG_STATUS_CKPT_EN.
- With the macro defined:
  - Adds ports ckpt_save (in, 1) and ckpt_restore (in, 1), plus a single shadow copy of pending and dependency.
  - ckpt_save copies the post-edge pending/dependency, including this cycle's mark, into the shadow.
  - Every commit also clears matching shadow pending bits, so the shadow stays consistent.
  - ckpt_restore loads the shadow into live state and ignores this cycle's mark; same-cycle commits still clear matching bits.
  - busy_count is recomputed from the restored state.
  - Priority: flush > restore > save.
- Without the macro: neither port exists and no shadow storage is present.

Test Plan:
- Reset mid-run with x5 pending -> immediately dec_pending = 0, dec_data = 0, busy_count = 0 without waiting for a clock edge.
- mark x3 -> rob 2; next cycle, commit x3 = 0xDEAD with rob 2 while decoding x3 -> same cycle dec_data = 0xDEAD, dec_pending = 0; following cycle pending cleared, busy_count = 0.
- mark x4 -> rob 1, then mark x4 -> rob 6, then commit x4 rob 1 = 0x11 -> data = 0x11, pending stays 1, dependency = 6, busy_count = 1.
- Commit and mark of x7 in the same cycle -> pending = 1, dependency = new rob id; rob_query_ready = 1 with 0x55 -> dec_data = 0x55, dec_pending = 0.
- Flush with x1, x2 pending and a commit x9 = 0x77 -> all pending 0, busy_count = 0, x9 reads 0x77; rdy_in low cycle with a mark -> no state change.
- CKPT: mark x1 -> rob 3, save, mark x2 -> rob 4, commit x1 rob 3, restore -> x1 not pending, x2 not pending, busy_count = 0.

Source files
------------

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status, same-cycle commit bypass and a busy counter.
// Define REG_STATUS_CKPT_EN to add a single checkpoint shadow of the rename status (ckpt_save / ckpt_restore).
module reg_status_file #(
    parameter int REG_COUNT    = 32,
    parameter int REG_ID_W     = 5,
    parameter int DATA_W       = 32,
    parameter int ROB_W        = 4,
    parameter int READ_PAIRS   = 1,
    parameter int COMMIT_PORTS = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               rdy_in,
    input  logic                               flush,
`ifdef REG_STATUS_CKPT_EN
    input  logic                               ckpt_save,
    input  logic                               ckpt_restore,
`endif
    input  logic [COMMIT_PORTS*REG_ID_W-1:0]   commit_reg_id,
    input  logic [COMMIT_PORTS*DATA_W-1:0]     commit_data,
    input  logic [COMMIT_PORTS*ROB_W-1:0]      commit_rob_id,
    output logic [2*READ_PAIRS*ROB_W-1:0]      rob_query_id,
    input  logic [2*READ_PAIRS-1:0]            rob_query_ready,
    input  logic [2*READ_PAIRS*DATA_W-1:0]     rob_query_data,
    input  logic [2*READ_PAIRS*REG_ID_W-1:0]   dec_reg_id,
    output logic [2*READ_PAIRS*DATA_W-1:0]     dec_data,
    output logic [2*READ_PAIRS-1:0]            dec_pending,
    output logic [2*READ_PAIRS*ROB_W-1:0]      dec_dependency,
    input  logic [REG_ID_W-1:0]                mark_reg_id,
    input  logic [ROB_W-1:0]                   mark_rob_id,
    output logic [REG_ID_W:0]                  busy_count
);
    localparam int SLOTS    = 2 * READ_PAIRS;
    localparam int ID_SPACE = 1 << REG_ID_W;

    // Read views span the whole id space so any decoded id indexes in range; id 0 and unused ids read as zero.
    logic [DATA_W-1:0]      data_view [ID_SPACE];
    logic [ROB_W-1:0]       dep_view  [ID_SPACE];
    logic [ID_SPACE-1:0]    pend_view;
    logic [REG_COUNT-1:1]   pending_next;
    logic [REG_ID_W:0]      busy_count_q, busy_count_d;

    genvar gi;

    for (gi = 0; gi < ID_SPACE; gi++) begin : g_view_zero
        if (gi == 0 || gi >= REG_COUNT) begin : g_zero
            assign data_view[gi] = '0;
            assign dep_view[gi]  = '0;
            assign pend_view[gi] = 1'b0;
        end
    end

    for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
        localparam logic [REG_ID_W-1:0] MY_ID = REG_ID_W'(gi);

        logic [DATA_W-1:0] data_q, data_d;
        logic [ROB_W-1:0]  dep_q, dep_d;
        logic              pending_q, pending_d;
        logic              commit_hit, live_clr;
        logic [DATA_W-1:0] commit_val;
`ifdef REG_STATUS_CKPT_EN
        logic              sh_pending_q, sh_pending_d;
        logic [ROB_W-1:0]  sh_dep_q, sh_dep_d;
        logic              sh_clr;
`endif

        // Ascending port scan: the highest-index (youngest) commit to this register wins.
        always_comb begin
            commit_hit = 1'b0;
            live_clr   = 1'b0;
            commit_val = '0;
`ifdef REG_STATUS_CKPT_EN
            sh_clr     = 1'b0;
`endif
            for (int p = 0; p < COMMIT_PORTS; p++) begin
                if (commit_reg_id[p*REG_ID_W +: REG_ID_W] == MY_ID) begin
                    commit_hit = 1'b1;
                    commit_val = commit_data[p*DATA_W +: DATA_W];
                    if (commit_rob_id[p*ROB_W +: ROB_W] == dep_q) begin
                        live_clr = 1'b1;
                    end
`ifdef REG_STATUS_CKPT_EN
                    if (commit_rob_id[p*ROB_W +: ROB_W] == sh_dep_q) begin
                        sh_clr = 1'b1;
                    end
`endif
                end
            end
        end

        always_comb begin
            data_d    = data_q;
            pending_d = pending_q;
            dep_d     = dep_q;
            if (rdy_in) begin
                if (commit_hit) begin
                    data_d = commit_val;
                end
                if (flush) begin
                    pending_d = 1'b0;
                    dep_d     = '0;
                end
`ifdef REG_STATUS_CKPT_EN
                else if (ckpt_restore) begin
                    pending_d = sh_pending_q & ~sh_clr;
                    dep_d     = sh_dep_q;
                end
`endif
                else if (mark_reg_id == MY_ID) begin
                    pending_d = 1'b1;
                    dep_d     = mark_rob_id;
                end else if (live_clr) begin
                    pending_d = 1'b0;
                end
            end
        end

`ifdef REG_STATUS_CKPT_EN
        // Commits keep the shadow coherent so a later restore never resurrects a retired producer.
        always_comb begin
            sh_pending_d = sh_pending_q;
            sh_dep_d     = sh_dep_q;
            if (rdy_in) begin
                if (sh_clr) begin
                    sh_pending_d = 1'b0;
                end
                if (!flush && !ckpt_restore && ckpt_save) begin
                    sh_pending_d = pending_d;
                    sh_dep_d     = dep_d;
                end
            end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                sh_pending_q <= 1'b0;
                sh_dep_q     <= '0;
            end else begin
                sh_pending_q <= sh_pending_d;
                sh_dep_q     <= sh_dep_d;
            end
        end
`endif

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                data_q    <= '0;
                pending_q <= 1'b0;
                dep_q     <= '0;
            end else begin
                data_q    <= data_d;
                pending_q <= pending_d;
                dep_q     <= dep_d;
            end
        end

        assign data_view[gi]    = data_q;
        assign dep_view[gi]     = dep_q;
        assign pend_view[gi]    = pending_q;
        assign pending_next[gi] = pending_d;
    end

    always_comb begin
        busy_count_d = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            busy_count_d = busy_count_d + (REG_ID_W+1)'(pending_next[r]);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_count_q <= '0;
        end else begin
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [REG_ID_W-1:0] id;
        logic [ROB_W-1:0]    dep;
        logic [DATA_W-1:0]   val;
        logic                pend;
        logic                hit;

        assign id  = dec_reg_id[gi*REG_ID_W +: REG_ID_W];
        assign dep = dep_view[id];

        // Resolution order for a pending source: same-cycle commit, then ROB result, else still pending.
        always_comb begin
            val  = data_view[id];
            pend = 1'b0;
            hit  = 1'b0;
            if (pend_view[id]) begin
                for (int p = 0; p < COMMIT_PORTS; p++) begin
                    if (commit_reg_id[p*REG_ID_W +: REG_ID_W] == id &&
                        commit_rob_id[p*ROB_W +: ROB_W] == dep) begin
                        hit = 1'b1;
                        val = commit_data[p*DATA_W +: DATA_W];
                    end
                end
                if (!hit) begin
                    if (rob_query_ready[gi]) begin
                        val = rob_query_data[gi*DATA_W +: DATA_W];
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
        end

        assign dec_data[gi*DATA_W +: DATA_W]     = val;
        assign dec_pending[gi]                   = pend;
        assign dec_dependency[gi*ROB_W +: ROB_W] = dep;
        assign rob_query_id[gi*ROB_W +: ROB_W]   = dep;
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: directed scenarios then random traffic against a behavioural model.
module tb_reg_status_file;
    localparam int NR = 32;
    localparam int IW = 5;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int RP = 1;
    localparam int CP = 2;
    localparam int NS = 2 * RP;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b0;
    logic flush  = 1'b0;
    logic ck_save = 1'b0;
    logic ck_restore = 1'b0;
    logic [CP*IW-1:0] commit_reg_id;
    logic [CP*DW-1:0] commit_data;
    logic [CP*RW-1:0] commit_rob_id;
    logic [NS*RW-1:0] rob_query_id;
    logic [NS-1:0]    rob_query_ready;
    logic [NS*DW-1:0] rob_query_data;
    logic [NS*IW-1:0] dec_reg_id;
    logic [NS*DW-1:0] dec_data;
    logic [NS-1:0]    dec_pending;
    logic [NS*RW-1:0] dec_dependency;
    logic [IW-1:0]    mark_reg_id;
    logic [RW-1:0]    mark_rob_id;
    logic [IW:0]      busy_count;

    always #5 clk_in = ~clk_in;

    reg_status_file #(.REG_COUNT(NR), .REG_ID_W(IW), .DATA_W(DW), .ROB_W(RW),
                      .READ_PAIRS(RP), .COMMIT_PORTS(CP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
`ifdef REG_STATUS_CKPT_EN
        .ckpt_save(ck_save), .ckpt_restore(ck_restore),
`endif
        .commit_reg_id(commit_reg_id), .commit_data(commit_data), .commit_rob_id(commit_rob_id),
        .rob_query_id(rob_query_id), .rob_query_ready(rob_query_ready), .rob_query_data(rob_query_data),
        .dec_reg_id(dec_reg_id), .dec_data(dec_data), .dec_pending(dec_pending),
        .dec_dependency(dec_dependency), .mark_reg_id(mark_reg_id), .mark_rob_id(mark_rob_id),
        .busy_count(busy_count)
    );

    // Behavioural model: plain arrays of architectural state plus the checkpoint shadow.
    logic [DW-1:0] m_data [NR];
    bit            m_pend [NR];
    logic [RW-1:0] m_dep  [NR];
    bit            s_pend [NR];
    logic [RW-1:0] s_dep  [NR];

    typedef struct packed {
        logic [31:0]            txn;
        logic [NS-1:0][DW-1:0]  data;
        logic [NS-1:0]          pend;
        logic [NS-1:0]          dchk;
        logic [NS-1:0][RW-1:0]  dep;
        logic [IW:0]            busy;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks = 0;
    int    errors = 0;
    int    txn_cnt = 0;

    task automatic chk(input string nm, input int txn, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s txn=%0d got=%h want=%h", nm, txn, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) begin
            m_data[r] = '0; m_pend[r] = 0; m_dep[r] = '0; s_pend[r] = 0; s_dep[r] = '0;
        end
    endfunction

    function automatic int model_busy();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic exp_t model_lookup();
        exp_t e;
        logic [IW-1:0] id;
        bit hit;
        e = '0;
        e.txn = txn_cnt;
        for (int s = 0; s < NS; s++) begin
            id = dec_reg_id[s*IW +: IW];
            e.dchk[s] = 1'b1;
            if (id != 0) begin
                e.dep[s] = m_dep[id];
                if (!m_pend[id]) begin
                    e.data[s] = m_data[id];
                end else begin
                    hit = 0;
                    for (int p = 0; p < CP; p++) begin
                        if (commit_reg_id[p*IW +: IW] == id && commit_rob_id[p*RW +: RW] == m_dep[id]) begin
                            hit = 1;
                            e.data[s] = commit_data[p*DW +: DW];
                        end
                    end
                    if (!hit && rob_query_ready[s]) begin
                        e.data[s] = rob_query_data[s*DW +: DW];
                    end else if (!hit) begin
                        e.pend[s] = 1'b1;
                        e.dchk[s] = 1'b0;
                    end
                end
            end
        end
        e.busy = (IW+1)'(model_busy());
        return e;
    endfunction

    function automatic void model_step();
        logic [RW-1:0] old_dep [NR];
        bit live_clr [NR];
        bit sh_clr [NR];
        logic [IW-1:0] cid;
        if (!rdy_in) return;
        for (int r = 0; r < NR; r++) begin
            old_dep[r] = m_dep[r]; live_clr[r] = 0; sh_clr[r] = 0;
        end
        for (int p = 0; p < CP; p++) begin
            cid = commit_reg_id[p*IW +: IW];
            if (cid != 0) begin
                m_data[cid] = commit_data[p*DW +: DW];
                if (commit_rob_id[p*RW +: RW] == old_dep[cid]) live_clr[cid] = 1;
                if (commit_rob_id[p*RW +: RW] == s_dep[cid])   sh_clr[cid] = 1;
            end
        end
        if (flush) begin
            for (int r = 0; r < NR; r++) begin m_pend[r] = 0; m_dep[r] = '0; end
        end else if (ck_restore) begin
            for (int r = 1; r < NR; r++) begin m_pend[r] = s_pend[r] && !sh_clr[r]; m_dep[r] = s_dep[r]; end
        end else begin
            for (int r = 1; r < NR; r++) if (live_clr[r]) m_pend[r] = 0;
            if (mark_reg_id != 0) begin m_pend[mark_reg_id] = 1; m_dep[mark_reg_id] = mark_rob_id; end
        end
        for (int r = 1; r < NR; r++) if (sh_clr[r]) s_pend[r] = 0;
        if (!flush && !ck_restore && ck_save) begin
            for (int r = 1; r < NR; r++) begin s_pend[r] = m_pend[r]; s_dep[r] = m_dep[r]; end
        end
    endfunction

    // Monitor: compares the oldest expectation against the DUT mid-cycle.
    exp_t  mon_e;
    string mon_tag;
    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            for (int s = 0; s < NS; s++) begin
                chk($sformatf("%s.pending%0d", mon_tag, s), mon_e.txn, 32'(dec_pending[s]), 32'(mon_e.pend[s]));
                chk($sformatf("%s.dep%0d", mon_tag, s), mon_e.txn, 32'(dec_dependency[s*RW +: RW]), 32'(mon_e.dep[s]));
                chk($sformatf("%s.qid%0d", mon_tag, s), mon_e.txn, 32'(rob_query_id[s*RW +: RW]), 32'(mon_e.dep[s]));
                if (mon_e.dchk[s])
                    chk($sformatf("%s.data%0d", mon_tag, s), mon_e.txn, dec_data[s*DW +: DW], mon_e.data[s]);
            end
            chk($sformatf("%s.busy", mon_tag), mon_e.txn, 32'(busy_count), 32'(mon_e.busy));
            $display("txn %0d %s: j=%h/%0d k=%h/%0d busy=%0d", mon_e.txn, mon_tag,
                     dec_data[DW-1:0], dec_pending[0], dec_data[2*DW-1:DW], dec_pending[1], busy_count);
        end
    end

    task automatic set_idle();
        rdy_in = 1'b1; flush = 1'b0; ck_save = 1'b0; ck_restore = 1'b0;
        commit_reg_id = '0; commit_data = '0; commit_rob_id = '0;
        mark_reg_id = '0; mark_rob_id = '0;
        dec_reg_id = '0; rob_query_ready = '0; rob_query_data = '0;
    endtask

    task automatic set_commit(input int p, input int id, input logic [DW-1:0] d, input int rob);
        commit_reg_id[p*IW +: IW] = IW'(id);
        commit_data[p*DW +: DW]   = d;
        commit_rob_id[p*RW +: RW] = RW'(rob);
    endtask

    task automatic set_dec(input int j, input int k);
        dec_reg_id[IW-1:0]    = IW'(j);
        dec_reg_id[2*IW-1:IW] = IW'(k);
    endtask

    task automatic cycle(input string tag);
        exp_q.push_back(model_lookup());
        tag_q.push_back(tag);
        txn_cnt++;
        @(posedge clk_in);
        if (!rst_in) model_step();
        #1;
    endtask

    task automatic do_mark(input int id, input int rob, input string tag);
        set_idle(); mark_reg_id = IW'(id); mark_rob_id = RW'(rob); cycle(tag);
    endtask

    initial begin
        model_reset();
        set_idle();
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        set_dec(3, 17);
        cycle("reset");
        rst_in = 1'b0;

        // Mark then commit with bypass.
        set_idle(); mark_reg_id = 5'd3; mark_rob_id = 4'd2; set_dec(3, 0); cycle("mark_x3_invisible");
        set_idle(); set_commit(0, 3, 32'hDEAD, 2); set_dec(3, 3); cycle("commit_x3_bypass");
        set_idle(); set_dec(3, 0); cycle("x3_cleared");

        // Stale commit must not clear a re-renamed register.
        do_mark(4, 1, "mark_x4_r1");
        do_mark(4, 6, "mark_x4_r6");
        set_idle(); set_commit(0, 4, 32'h11, 1); cycle("commit_x4_stale");
        set_idle(); set_dec(4, 4); cycle("x4_still_pending");

        // Commit and mark of the same register in one cycle.
        set_idle(); set_commit(0, 7, 32'h70, 0); mark_reg_id = 5'd7; mark_rob_id = 4'd9; cycle("commit_mark_x7");
        set_idle(); set_dec(7, 7); rob_query_ready = 2'b01; rob_query_data[DW-1:0] = 32'h55; cycle("x7_rob_ready");

        // Two commit ports on one register: the higher port wins, for data and for bypass.
        set_idle(); set_commit(0, 20, 32'hAAAA, 0); set_commit(1, 20, 32'hBBBB, 0); cycle("dual_commit_x20");
        do_mark(21, 3, "mark_x21");
        set_idle(); set_commit(0, 21, 32'h1111, 3); set_commit(1, 21, 32'h2222, 3); set_dec(20, 21);
        cycle("dual_bypass_x21");

        // Flush with pending registers and a same-cycle commit.
        do_mark(1, 5, "mark_x1");
        do_mark(2, 7, "mark_x2");
        set_idle(); flush = 1'b1; set_commit(1, 9, 32'h77, 0); mark_reg_id = 5'd10; mark_rob_id = 4'd2;
        set_dec(1, 2); cycle("flush");
        set_idle(); set_dec(9, 4); cycle("after_flush");
        set_idle(); rdy_in = 1'b0; mark_reg_id = 5'd12; mark_rob_id = 4'd3; set_commit(0, 12, 32'h99, 0);
        cycle("rdy_low");
        set_idle(); set_dec(12, 10); cycle("after_rdy_low");

`ifdef REG_STATUS_CKPT_EN
        do_mark(1, 3, "ck_mark_x1");
        set_idle(); ck_save = 1'b1; cycle("ck_save");
        do_mark(2, 4, "ck_mark_x2");
        set_idle(); ck_restore = 1'b1; set_commit(0, 1, 32'h31, 3); cycle("ck_restore");
        set_idle(); set_dec(1, 2); cycle("ck_after");
`endif

        // Asynchronous reset with a pending register.
        do_mark(5, 4, "mark_x5");
        set_idle(); set_dec(5, 5); cycle("x5_pending");
        set_idle(); set_dec(5, 3); rst_in = 1'b1; model_reset(); cycle("async_reset");
        rst_in = 1'b0;

        // Random traffic over a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            int cid;
            set_idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 29) == 0);
            ck_save    = ($urandom_range(0, 9) == 0);
            ck_restore = ($urandom_range(0, 14) == 0);
            for (int p = 0; p < CP; p++) begin
                cid = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
                set_commit(p, cid, $urandom, ($urandom_range(0, 1) == 1) ? int'(m_dep[cid]) : int'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 1) == 1) begin
                mark_reg_id = IW'($urandom_range(0, 7));
                mark_rob_id = RW'($urandom_range(0, 15));
            end
            set_dec(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
            rob_query_ready = NS'($urandom_range(0, 3));
            rob_query_data  = {$urandom, $urandom};
`ifndef REG_STATUS_CKPT_EN
            ck_save = 1'b0; ck_restore = 1'b0;
`endif
            cycle("random");
        end

        set_idle();
        #10;
        chk("queue_drained", txn_cnt, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
